// File: rtl/minmax_pkg.sv
// Shared definitions for the running min/max controller and its datapath.
// Holds the 3-bit controller state encoding and the datapath min/max init values.
// No ports; imported with import minmax_pkg::*.
package minmax_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    LOAD   = 3'd2,
    SETTLE = 3'd3,
    UPD    = 3'd4,
    DONE   = 3'd5
  } state_t;

  // min starts at the largest signed value, max at the smallest, so the
  // first real sample always replaces both unless it is itself an extreme.
  localparam logic [31:0] MIN_INIT = 32'h7FFF_FFFF;
  localparam logic [31:0] MAX_INIT = 32'h8000_0000;

endpackage

// File: rtl/minmax_ctrl_cnt.sv
// Sample counter for minmax_ctrl: latches the run length and counts completed samples.
// Ports: clk/rst (async, active-high); load latches n_samples into target and clears cnt;
//        inc advances cnt; last = (cnt+1 == target) at CNT_W bits; empty = (target == 0).
module minmax_ctrl_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic [CNT_W-1:0] n_samples,
  output logic             last,
  output logic             empty
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] cnt_plus1;

  // Compare wraps at CNT_W bits, so target = 2^CNT_W-1 is the longest run.
  assign cnt_plus1 = cnt + CNT_W'(1);
  assign last      = (cnt_plus1 == target);
  assign empty     = (target == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      target <= '0;
    end else if (load) begin
      cnt    <= '0;
      target <= n_samples;
    end else if (inc) begin
      cnt    <= cnt_plus1;
    end
  end

endmodule

// File: rtl/minmax_ctrl.sv
// Control unit for the running min/max datapath: handshakes samples in and sequences
// clear/load strobes, pulsing done after n_samples samples (min 3 cycles per sample).
// Ports: clk, rst (async active-high), start, n_samples, in_valid/in_ready handshake,
//        A_lt_B/C_gt_D datapath flags, reg/min/max clr+ld strobes, busy, done.
// Optional: define MINMAX_CTRL_ABORT_EN to add the abort input (forces IDLE, no strobes).
module minmax_ctrl
  import minmax_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             A_lt_B,
  input  logic             C_gt_D,
`ifdef MINMAX_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             reg_clr,
  output logic             reg_ld,
  output logic             min_clr,
  output logic             min_ld,
  output logic             max_clr,
  output logic             max_ld,
  output logic             busy,
  output logic             done
);

  state_t state;
  state_t state_nxt;
  logic   cnt_load;
  logic   cnt_inc;
  logic   last;
  logic   empty;
  logic   kill;

`ifdef MINMAX_CTRL_ABORT_EN
  assign kill = abort && (state != IDLE);
`else
  assign kill = 1'b0;
`endif

  minmax_ctrl_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .inc       (cnt_inc),
    .n_samples (n_samples),
    .last      (last),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    reg_clr   = 1'b0;
    reg_ld    = 1'b0;
    min_clr   = 1'b0;
    min_ld    = 1'b0;
    max_clr   = 1'b0;
    max_ld    = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          cnt_load  = 1'b1;
          state_nxt = INIT;
        end
      end
      INIT: begin
        reg_clr   = 1'b1;
        min_clr   = 1'b1;
        max_clr   = 1'b1;
        state_nxt = empty ? DONE : LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        // Mealy load: the register captures the sample on the handshake edge.
        reg_ld   = in_valid;
        if (in_valid) state_nxt = SETTLE;
      end
      SETTLE: begin
        // Idle cycle so the datapath flags reflect the newly loaded sample.
        state_nxt = UPD;
      end
      UPD: begin
        min_ld    = A_lt_B;
        max_ld    = C_gt_D;
        cnt_inc   = 1'b1;
        state_nxt = last ? DONE : LOAD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Abort overrides every transition and suppresses all strobes this cycle.
    if (kill) begin
      state_nxt = IDLE;
      in_ready  = 1'b0;
      reg_clr   = 1'b0;
      reg_ld    = 1'b0;
      min_clr   = 1'b0;
      min_ld    = 1'b0;
      max_clr   = 1'b0;
      max_ld    = 1'b0;
      done      = 1'b0;
      cnt_load  = 1'b0;
      cnt_inc   = 1'b0;
    end
  end

endmodule

// File: tb/tb_minmax_ctrl.sv
// Self-checking bench for minmax_ctrl with a behavioural datapath and a running min/max model.
module tb_minmax_ctrl;
  import minmax_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] n_samples = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             a_lt_b = 1'b0;
  logic             c_gt_d = 1'b0;
  logic             abort = 1'b0;
  logic             reg_clr, reg_ld, min_clr, min_ld, max_clr, max_ld, busy, done;
  logic [31:0]      din = '0;

  // Behavioural datapath: register, min, max and registered compare flags.
  logic [31:0] dp_reg = '0;
  logic [31:0] dp_min = '0;
  logic [31:0] dp_max = '0;

  logic [31:0] smp [0:15];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  minmax_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_samples (n_samples),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A_lt_B    (a_lt_b),
    .C_gt_D    (c_gt_d),
`ifdef MINMAX_CTRL_ABORT_EN
    .abort     (abort),
`endif
    .reg_clr   (reg_clr),
    .reg_ld    (reg_ld),
    .min_clr   (min_clr),
    .min_ld    (min_ld),
    .max_clr   (max_clr),
    .max_ld    (max_ld),
    .busy      (busy),
    .done      (done)
  );

  always @(posedge clk) begin
    if (reg_clr)     dp_reg <= '0;
    else if (reg_ld) dp_reg <= din;
    if (min_clr)     dp_min <= MIN_INIT;
    else if (min_ld) dp_min <= dp_reg;
    if (max_clr)     dp_max <= MAX_INIT;
    else if (max_ld) dp_max <= dp_reg;
    a_lt_b <= $signed(dp_reg) < $signed(dp_min);
    c_gt_d <= $signed(dp_reg) > $signed(dp_max);
  end

  // One complete run of n samples; stall = cycles of in_valid low while in_ready is high.
  // With hold_start, start stays high throughout and must be ignored outside IDLE.
  task automatic run_check(input int n, input int stall, input bit hold_start);
    int t, k, u, hs_t, stall_left, exp_t;
    bit seen_done, exp_min_ld, exp_max_ld;
    logic [31:0] rmin, rmax;
    @(negedge clk);
    start     = 1'b1;
    n_samples = CNT_W'(n);
    in_valid  = 1'b0;
    @(posedge clk);
    t = 1; k = 0; u = 0; hs_t = -10; stall_left = stall; seen_done = 1'b0;
    rmin = MIN_INIT; rmax = MAX_INIT;
    exp_t = 3 * n + 2 + ((n > 0) ? stall : 0);
    while (!seen_done && t <= exp_t + 3) begin
      @(negedge clk);
      if (!hold_start) begin
        start     = 1'b0;
        n_samples = CNT_W'($urandom_range(0, 15));
      end
      in_valid = (k < n) && (stall_left == 0);
      din      = (k < n) ? smp[k] : $urandom;
      #1;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy t=%0d: got %b want 1", t, busy); end
      checks++;
      if (done !== (t == exp_t)) begin errors++; $display("FAIL done_time t=%0d: got %b want %b", t, done, t == exp_t); end
      checks++;
      if ({reg_clr, min_clr, max_clr} !== {3{t == 1}}) begin
        errors++; $display("FAIL clr t=%0d: got %b want %b", t, {reg_clr, min_clr, max_clr}, {3{t == 1}});
      end
      if (t == 2 && n > 0) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL first_ready: got %b want 1", in_ready); end
      end
      if (t < 2) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_in_init t=%0d: got %b want 0", t, in_ready); end
      end
      checks++;
      if (reg_ld !== (in_ready && in_valid)) begin
        errors++; $display("FAIL reg_ld t=%0d: got %b want %b", t, reg_ld, in_ready && in_valid);
      end
      if (t == hs_t + 2) begin
        exp_min_ld = $signed(smp[u]) < $signed(rmin);
        exp_max_ld = $signed(smp[u]) > $signed(rmax);
        checks++;
        if ({min_ld, max_ld} !== {exp_min_ld, exp_max_ld}) begin
          errors++; $display("FAIL upd_ld sample=%0d: got %b%b want %b%b", u, min_ld, max_ld, exp_min_ld, exp_max_ld);
        end
        if (exp_min_ld) rmin = smp[u];
        if (exp_max_ld) rmax = smp[u];
        u++;
      end else begin
        checks++;
        if ({min_ld, max_ld} !== 2'b00) begin errors++; $display("FAIL stray_ld t=%0d: got %b%b want 00", t, min_ld, max_ld); end
      end
      if (in_ready && !in_valid && stall_left > 0) stall_left--;
      if (in_ready && in_valid) begin k++; hs_t = t; end
      if (done === 1'b1) begin
        seen_done = 1'b1;
        checks++;
        if (dp_min !== rmin || dp_max !== rmax) begin
          errors++; $display("FAIL final_minmax: got %h/%h want %h/%h", dp_min, dp_max, rmin, rmax);
        end
        checks++;
        if (k != n) begin errors++; $display("FAIL sample_count: got %0d want %0d", k, n); end
      end
      @(posedge clk);
      t++;
    end
    checks++;
    if (!seen_done) begin errors++; $display("FAIL run_timeout: got no done want done at t=%0d", exp_t); end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({in_ready, busy, done, reg_clr, reg_ld, min_clr, min_ld, max_clr, max_ld} !== 9'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 0", {in_ready, busy, done, reg_clr, reg_ld, min_clr, min_ld, max_clr, max_ld});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic;
    smp[0] = 32'd5; smp[1] = -32'sd3; smp[2] = 32'd12; smp[3] = 32'd7;
    run_check(4, 0, 1'b0);
    checks++;
    if (dp_min !== -32'sd3 || dp_max !== 32'd12) begin
      errors++; $display("FAIL basic_minmax: got %h/%h want fffffffd/0000000c", dp_min, dp_max);
    end
  endtask

  task automatic test_backpressure;
    smp[0] = 32'd100; smp[1] = 32'd50;
    run_check(2, 5, 1'b0);
  endtask

  task automatic test_zero_length;
    run_check(0, 0, 1'b0);
  endtask

  task automatic test_extreme;
    smp[0] = 32'h7FFF_FFFF;
    run_check(1, 0, 1'b0);
  endtask

  task automatic test_max_length;
    for (int i = 0; i < 15; i++) smp[i] = $urandom;
    run_check(15, 0, 1'b0);
  endtask

  task automatic test_random;
    int n;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < 16; i++) smp[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10;
      run_check(n, $urandom_range(0, 3), 1'b0);
    end
  endtask

  task automatic test_reset_mid_run;
    int k, cyc;
    smp[0] = 32'd3; smp[1] = 32'd8; smp[2] = 32'd1;
    @(negedge clk);
    start = 1'b1; n_samples = CNT_W'(3);
    k = 0; cyc = 0;
    while (k < 2 && cyc < 40) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; din = smp[k];
      #1;
      if (in_ready && in_valid) k++;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL settle_state: got busy=%b ready=%b want 1/0", busy, in_ready); end
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, busy, done, reg_clr, reg_ld, min_clr, min_ld, max_clr, max_ld} !== 9'b0) begin
      errors++; $display("FAIL async_reset: got %b want 0", {in_ready, busy, done, reg_clr, reg_ld, min_clr, min_ld, max_clr, max_ld});
    end
    @(negedge clk);
    rst = 1'b0;
    smp[0] = 32'd9;
    run_check(1, 0, 1'b0);
    checks++;
    if (dp_min !== 32'd9 || dp_max !== 32'd9) begin errors++; $display("FAIL after_reset_run: got %h/%h want 9/9", dp_min, dp_max); end
  endtask

  task automatic test_back_to_back;
    smp[0] = 32'd4; smp[1] = 32'd2;
    run_check(2, 0, 1'b1);
    @(negedge clk);
    n_samples = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || reg_clr !== 1'b1) begin errors++; $display("FAIL b2b_restart: got busy=%b clr=%b want 1/1", busy, reg_clr); end
    start = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_zero_done: got %b want 1", done); end
    @(negedge clk);
  endtask

`ifdef MINMAX_CTRL_ABORT_EN
  task automatic test_abort;
    int k, cyc;
    smp[0] = 32'd6; smp[1] = 32'd7;
    @(negedge clk);
    start = 1'b1; n_samples = CNT_W'(2);
    k = 0; cyc = 0;
    while (k < 1 && cyc < 40) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; din = smp[k];
      #1;
      if (in_ready && in_valid) k++;
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    #1;
    checks++;
    if ({min_ld, max_ld, done} !== 3'b000) begin errors++; $display("FAIL abort_strobes: got %b want 000", {min_ld, max_ld, done}); end
    @(negedge clk);
    abort = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b want 0", busy); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_length();
    test_extreme();
    test_max_length();
    test_random();
    test_reset_mid_run();
    test_back_to_back();
`ifdef MINMAX_CTRL_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/minmax_ctrl.md
# minmax_ctrl

Control unit for the running min/max HLSM. Sits directly upstream of the min/max datapath: it accepts a sample stream over a valid/ready handshake, sequences the datapath's clear and load strobes, consumes its `A_lt_B` (sample < min) and `C_gt_D` (sample > max) flags, and signals completion after a programmed number of samples. The sample bus itself goes straight to the datapath's `in`. This block only decides when it is loaded.

## Interface
- `CNT_W`, default 16: width of the sample counter and of `n_samples`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a run. Sampled only in IDLE.
- `n_samples` in CNT_W: samples per run. Latched on accepted `start`.
- `in_valid` in 1: upstream sample valid.
- `in_ready` out 1: controller can accept a sample.
- `A_lt_B` in 1: datapath flag, register < min.
- `C_gt_D` in 1: datapath flag, register > max.
- `reg_clr`, `reg_ld`, `min_clr`, `min_ld`, `max_clr`, `max_ld` out 1 each: datapath strobes.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at end of run.
- `abort` in 1: present only with `MINMAX_CTRL_ABORT_EN`.

## Operation
States are IDLE, INIT, LOAD, SETTLE, UPD and DONE. Outputs are Moore decodes of state, except where noted.

- **IDLE**
  - All strobes low. `in_ready`=0.
  - `start`=1: latch `n_samples` into `target`, clear `cnt`, go to INIT.
- **INIT** (1 cycle)
  - `reg_clr`=`min_clr`=`max_clr`=1. The datapath loads min=0x7FFFFFFF and max=0x80000000.
  - If `target`==0, go to DONE. Otherwise go to LOAD.
- **LOAD**
  - `in_ready`=1. `reg_ld` = `in_valid` (Mealy).
  - Handshake occurs when `in_valid`&&`in_ready`: go to SETTLE. Otherwise stay in LOAD.
- **SETTLE** (1 cycle)
  - No strobes. This gives the datapath one edge to register its flags for the new sample.
- **UPD** (1 cycle)
  - `min_ld` = `A_lt_B`, `max_ld` = `C_gt_D`, taken combinationally from the flags.
  - `cnt` <= `cnt`+1.
  - If `cnt`+1 == `target`, go to DONE. Otherwise go to LOAD.
- **DONE** (1 cycle)
  - `done`=1, then go to IDLE.

Rules:
- `start` outside IDLE is ignored.
- `n_samples` changes after latching have no effect on the current run.
- `cnt`+1 is compared at CNT_W bits. `target` = 2^CNT_W−1 is the largest run length.
- `reg_ld` is never asserted outside LOAD. This guarantees the datapath register is stable from the load edge through the UPD edge.
- In UPD, `min_ld` and `max_ld` are never both 1 for the same sample, except on the first sample after INIT, where both are 1 unless the value is an extreme.

## Timing
- Reset values:
  - state IDLE; `cnt`=0; `target`=0.
  - `in_ready`=0, `busy`=0, `done`=0, all strobes 0.
- Start to first `in_ready`: 2 cycles (IDLE edge, INIT edge).
- Per sample:
  - Handshake edge (`reg_ld`) → SETTLE edge → UPD edge (`min_ld`/`max_ld`).
  - Minimum 3 cycles per sample.
  - Updated min/max are visible on the datapath outputs after the UPD edge.
- `done` rises 1 cycle after the final UPD edge. Min/max are final at that point.
- Reset mid-run: return to IDLE immediately and drop all strobes.
  - Datapath min/max are left untouched; the next run's INIT clears them.
- Back-to-back runs: `start` held high during DONE is not accepted. It is accepted in the following IDLE cycle.

## Configuration
- `MINMAX_CTRL_ABORT_EN` defined:
  - `abort` port exists. `abort`=1 in any non-IDLE state forces IDLE at the next edge.
  - No `done` pulse and no strobes in that cycle. Abort has priority over every other transition.
- Not defined: no `abort` port; runs always complete.

## Structure
- Shared package `minmax_pkg`:
  - 3-bit state encoding constants: IDLE=0, INIT=1, LOAD=2, SETTLE=3, UPD=4, DONE=5.
  - Datapath init constants MIN_INIT=0x7FFFFFFF and MAX_INIT=0x80000000, shared with the datapath.
- One sub-module, `minmax_ctrl_cnt`:
  - CNT_W-bit counter with clear and increment.
  - Compare output `last` = (`cnt`+1 == `target`).

## Test plan
- **Basic run.** Reset, then `n_samples`=4 and stream 5, −3, 12, 7.
  - `min_ld`/`max_ld` pattern: (1,1), (1,0), (0,1), (0,0).
  - Final min=−3, max=12; `done` 1 cycle after the 4th UPD.
- **Backpressure.** `n_samples`=2, with `in_valid` low for 5 cycles in LOAD.
  - `in_ready` stays 1 and `reg_ld` stays 0 until `in_valid`.
  - Total run = 2 + 5 + 6 + 1 cycles.
- **Zero length.** `n_samples`=0.
  - INIT, then DONE.
  - `done` 2 cycles after `start`; no `reg_ld`; min=0x7FFFFFFF, max=0x80000000.
- **Extreme value.** Single sample 0x7FFFFFFF.
  - `min_ld`=0, `max_ld`=1.
  - Final min=max=0x7FFFFFFF.
- **Reset mid-run.** Assert `rst` during SETTLE of sample 2 of 3.
  - All outputs go to 0 asynchronously.
  - A new `start` with 1 sample of value 9 gives min=max=9.
- **Abort (with `MINMAX_CTRL_ABORT_EN`).** `abort` in UPD.
  - No `min_ld`/`max_ld` at that edge; IDLE next; `done` never pulses.
